// File: rtl/ahb_lite_manager_if.sv
// AHB-Lite bus bundle between the manager and one subordinate.
// The master modport is the manager side; the slave modport is the subordinate side.
interface ahb_lite_manager_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic [1:0]            hsize;
  logic                  hwrite;
  logic                  hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hresp;
  logic                  hready;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hburst, hwdata,
    input  hrdata, hresp, hready
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hburst, hwdata,
    output hrdata, hresp, hready
  );
endinterface

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns one command into a SINGLE or INCR burst, streaming
// write beats in and read beats out.
// Optional feature macro: AHB_MGR_TIMEOUT_EN (data-phase wait-state timeout
// after TIMEOUT_CYCLES consecutive hready=0 cycles).
module ahb_lite_manager #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  ahb_lite_manager_if.master    bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  // Wide enough that addr + len*8 never wraps while checking the end bound.
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 4;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            size_reg;
  logic                  write_reg;
  logic                  burst_reg;
  // Address phases still to be issued for the current command.
  logic [LEN_WIDTH-1:0]  left_reg;
  // In PIPE: a NONSEQ/SEQ data phase is in flight (cleared after a BUSY).
  logic                  pend_reg;
  logic [DATA_WIDTH-1:0] hwdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rdata_valid_reg;
  logic                  done_reg, err_reg;
  logic                  done_next, err_next;
  logic [1:0]            htrans_c;
  logic                  addr_ok, data_phase, beat_ok, timeout_hit, reject;
  logic [2:0]            lane_mask;
  logic [SUM_W-1:0]      cmd_end;

  // Command legality: non-zero length, size-aligned start, burst stays inside the address space.
  always_comb begin
    case (cmd_size)
      2'd0:    lane_mask = 3'b000;
      2'd1:    lane_mask = 3'b001;
      2'd2:    lane_mask = 3'b011;
      default: lane_mask = 3'b111;
    endcase
    cmd_end = SUM_W'(cmd_addr) + (SUM_W'(cmd_len) << cmd_size);
    reject  = (cmd_len == '0) || (|(cmd_addr[2:0] & lane_mask)) ||
              (cmd_end > (SUM_W'(1) << ADDR_WIDTH));
  end

  assign addr_ok    = htrans_c[1] && bus.hready;
  assign data_phase = ((state_reg == S_PIPE) && pend_reg) || (state_reg == S_LAST) ||
                      (state_reg == S_ERR);
  assign beat_ok    = data_phase && (state_reg != S_ERR) && bus.hready && !bus.hresp;

`ifdef AHB_MGR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;

  // Count consecutive stalled data-phase cycles; any hready=1 restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !data_phase || bus.hready) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  assign timeout_hit = data_phase && !bus.hready && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the limit has no meaning; fold it into a dead net.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and completion decode.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            state_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (addr_ok) state_next = (left_reg == LEN_WIDTH'(1)) ? S_LAST : S_PIPE;
      end
      S_PIPE: begin
        if (pend_reg && bus.hresp) begin
          if (bus.hready) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next = S_ERR;
          end
        end else if (addr_ok) begin
          state_next = (left_reg == LEN_WIDTH'(1)) ? S_LAST : S_PIPE;
        end
      end
      S_LAST: begin
        if (bus.hresp) begin
          if (bus.hready) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next = S_ERR;
          end
        end else if (bus.hready) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      S_ERR: begin
        if (bus.hready) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_next = S_IDLE;
      done_next  = 1'b1;
      err_next   = 1'b1;
    end
  end

  // Bus and handshake outputs; a write address phase is only offered once its beat is present.
  always_comb begin
    htrans_c = HT_IDLE;
    case (state_reg)
      S_ADDR:  if (!write_reg || wdata_valid) htrans_c = HT_NONSEQ;
      S_PIPE:  htrans_c = (!write_reg || wdata_valid) ? HT_SEQ : HT_BUSY;
      default: htrans_c = HT_IDLE;
    endcase
    bus.htrans = htrans_c;
    bus.hsel   = (htrans_c != HT_IDLE);
    if (state_reg == S_IDLE) begin
      bus.haddr  = '0;
      bus.hsize  = 2'b00;
      bus.hwrite = 1'b0;
      bus.hburst = 1'b0;
    end else begin
      bus.haddr  = addr_reg;
      bus.hsize  = size_reg;
      bus.hwrite = write_reg;
      bus.hburst = burst_reg;
    end
    bus.hwdata  = hwdata_reg;
    cmd_ready   = (state_reg == S_IDLE);
    wdata_ready = write_reg && addr_ok;
    rdata       = rdata_reg;
    rdata_valid = rdata_valid_reg;
    done        = done_reg;
    err         = err_reg;
  end

  // Command capture, address stepping, write-beat capture and read-beat return.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg        <= '0;
      size_reg        <= 2'b00;
      write_reg       <= 1'b0;
      burst_reg       <= 1'b0;
      left_reg        <= '0;
      pend_reg        <= 1'b0;
      hwdata_reg      <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      done_reg        <= done_next;
      err_reg         <= err_next;
      rdata_valid_reg <= beat_ok && !write_reg;
      if (beat_ok && !write_reg) rdata_reg <= bus.hrdata;
      if (state_reg == S_IDLE) begin
        if (cmd_valid) begin
          addr_reg  <= cmd_addr;
          size_reg  <= cmd_size;
          write_reg <= cmd_write;
          burst_reg <= (cmd_len != LEN_WIDTH'(1));
          left_reg  <= cmd_len;
        end
      end else if (addr_ok) begin
        addr_reg <= addr_reg + (ADDR_WIDTH'(1) << size_reg);
        left_reg <= left_reg - LEN_WIDTH'(1);
      end
      if (write_reg && addr_ok) hwdata_reg <= wdata;
      pend_reg <= (state_next == S_PIPE) && (addr_ok || (pend_reg && !bus.hready));
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager: one-line log per command, hand-computed expectations.
module tb_ahb_lite_manager;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdata, rdata;
  logic          wdata_valid, wdata_ready, rdata_valid, done, err;
  int            checks = 0;
  int            errors = 0;

  ahb_lite_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_lite_manager #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns one cycle after acceptance with cmd_valid low.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic [LW-1:0] len);
    cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_len = len; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = 2'd0;
    cmd_len = '0; wdata = '0; wdata_valid = 1'b0;
    bus.hrdata = '0; bus.hresp = 1'b0; bus.hready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_hsel", bus.hsel, 1'b0);
    chk("rst_haddr", bus.haddr, 10'h000);
    chk("rst_outs", {done, err, rdata_valid, wdata_ready}, 4'b0000);
    chk("rst_rdata", rdata, 64'h0);
    rst = 1'b0;
    next_cycle();

    // ---- single write, zero waits
    $display("txn write single addr=0x010");
    send_cmd(1'b1, 10'h010, 2'd2, 8'd1);
    wdata = 64'hDEADBEEF; wdata_valid = 1'b1; #1;
    chk("w1_htrans", bus.htrans, 2'b10);
    chk("w1_haddr", bus.haddr, 10'h010);
    chk("w1_ctrl", {bus.hsel, bus.hwrite, bus.hburst, bus.hsize}, 5'b11010);
    chk("w1_wdata_ready", wdata_ready, 1'b1);
    next_cycle(); wdata_valid = 1'b0; #1;
    chk("w1_data_htrans", bus.htrans, 2'b00);
    chk("w1_hwdata", bus.hwdata, 64'hDEADBEEF);
    chk("w1_no_done_yet", done, 1'b0);
    next_cycle(); #1;
    chk("w1_done", {done, err, cmd_ready}, 3'b101);
    next_cycle(); #1;
    chk("w1_done_pulse", done, 1'b0);

    // ---- read INCR len 4, two wait states on beat 2
    $display("txn read incr addr=0x100 len=4 waits=2");
    send_cmd(1'b0, 10'h100, 2'd3, 8'd4); #1;
    chk("r4_c1_htrans", bus.htrans, 2'b10);
    chk("r4_c1_haddr", bus.haddr, 10'h100);
    chk("r4_c1_hburst", bus.hburst, 1'b1);
    next_cycle(); bus.hrdata = 64'h1111; #1;
    chk("r4_c2_trans_addr", {bus.htrans, bus.haddr}, {2'b11, 10'h108});
    next_cycle(); bus.hrdata = 64'hBAD; bus.hready = 1'b0; #1;
    chk("r4_c3_rvalid", rdata_valid, 1'b1);
    chk("r4_c3_rdata", rdata, 64'h1111);
    chk("r4_c3_trans_addr", {bus.htrans, bus.haddr}, {2'b11, 10'h110});
    next_cycle(); #1;
    chk("r4_c4_rvalid", rdata_valid, 1'b0);
    chk("r4_c4_hold", {bus.htrans, bus.haddr}, {2'b11, 10'h110});
    next_cycle(); bus.hready = 1'b1; bus.hrdata = 64'h2222; #1;
    chk("r4_c5_hold", {bus.htrans, bus.haddr, rdata_valid}, {2'b11, 10'h110, 1'b0});
    next_cycle(); bus.hrdata = 64'h3333; #1;
    chk("r4_c6_rdata", {rdata_valid, rdata}, {1'b1, 64'h2222});
    chk("r4_c6_trans_addr", {bus.htrans, bus.haddr}, {2'b11, 10'h118});
    next_cycle(); bus.hrdata = 64'h4444; #1;
    chk("r4_c7_rdata", {rdata_valid, rdata}, {1'b1, 64'h3333});
    chk("r4_c7_last_idle", {bus.htrans, bus.hsel, done}, 4'b0000);
    next_cycle(); #1;
    chk("r4_c8_rdata", {rdata_valid, rdata}, {1'b1, 64'h4444});
    chk("r4_c8_done", {done, err, cmd_ready}, 3'b101);
    next_cycle(); #1;
    chk("r4_c9_quiet", {done, rdata_valid}, 2'b00);

    // ---- write INCR len 3 with two BUSY cycles before beat 2
    $display("txn write incr addr=0x040 len=3 busy=2");
    send_cmd(1'b1, 10'h040, 2'd2, 8'd3);
    wdata = 64'hA1; wdata_valid = 1'b1; #1;
    chk("w3_c1", {bus.htrans, bus.haddr, wdata_ready}, {2'b10, 10'h040, 1'b1});
    next_cycle(); wdata_valid = 1'b0; #1;
    chk("w3_c2_busy", {bus.htrans, bus.haddr, bus.hsel, wdata_ready}, {2'b01, 10'h044, 2'b10});
    chk("w3_c2_hwdata", bus.hwdata, 64'hA1);
    next_cycle(); #1;
    chk("w3_c3_busy", {bus.htrans, bus.haddr}, {2'b01, 10'h044});
    next_cycle(); wdata = 64'hA2; wdata_valid = 1'b1; #1;
    chk("w3_c4_seq", {bus.htrans, bus.haddr, wdata_ready}, {2'b11, 10'h044, 1'b1});
    next_cycle(); wdata = 64'hA3; #1;
    chk("w3_c5_seq", {bus.htrans, bus.haddr, wdata_ready}, {2'b11, 10'h048, 1'b1});
    chk("w3_c5_hwdata", bus.hwdata, 64'hA2);
    next_cycle(); wdata_valid = 1'b0; #1;
    chk("w3_c6_last", {bus.htrans, wdata_ready, done}, 4'b0000);
    chk("w3_c6_hwdata", bus.hwdata, 64'hA3);
    next_cycle(); #1;
    chk("w3_done", {done, err}, 2'b10);

    // ---- read len 4 with an error response on beat 2
    $display("txn read incr addr=0x200 len=4 hresp on beat 2");
    next_cycle();
    send_cmd(1'b0, 10'h200, 2'd3, 8'd4); #1;
    chk("re_c1", {bus.htrans, bus.haddr}, {2'b10, 10'h200});
    next_cycle(); bus.hrdata = 64'h5555; #1;
    next_cycle(); bus.hready = 1'b0; bus.hresp = 1'b1; #1;
    chk("re_c3_rdata", {rdata_valid, rdata}, {1'b1, 64'h5555});
    chk("re_c3_seq", {bus.htrans, bus.haddr}, {2'b11, 10'h210});
    next_cycle(); bus.hready = 1'b1; #1;
    chk("re_c4_cancel", {bus.htrans, bus.hsel, rdata_valid, done}, 5'b00000);
    next_cycle(); bus.hresp = 1'b0; #1;
    chk("re_c5_done", {done, err, rdata_valid, cmd_ready}, 4'b1101);
    next_cycle(); #1;
    chk("re_c6_quiet", {done, err, rdata_valid}, 3'b000);

    // ---- rejects: 1KB crossing, misaligned, zero length; then the exact-fit boundary
    $display("txn reject addr=0x3FC size=2 len=2");
    send_cmd(1'b0, 10'h3FC, 2'd2, 8'd2); #1;
    chk("rej_cross", {done, err, bus.hsel, bus.htrans, cmd_ready}, 6'b110001);
    $display("txn reject addr=0x002 size=2 len=1");
    send_cmd(1'b1, 10'h002, 2'd2, 8'd1); #1;
    chk("rej_misalign", {done, err, bus.hsel, bus.htrans}, 5'b11000);
    $display("txn reject len=0");
    send_cmd(1'b0, 10'h000, 2'd0, 8'd0); #1;
    chk("rej_len0", {done, err, bus.hsel}, 3'b110);
    next_cycle(); #1;
    chk("rej_pulse", {done, err, bus.hsel}, 3'b000);
    $display("txn read addr=0x3F8 size=2 len=2 (ends at top byte)");
    send_cmd(1'b0, 10'h3F8, 2'd2, 8'd2); #1;
    chk("fit_c1", {bus.htrans, bus.haddr, done}, {2'b10, 10'h3F8, 1'b0});
    next_cycle(); #1;
    chk("fit_c2", {bus.htrans, bus.haddr}, {2'b11, 10'h3FC});
    next_cycle(); next_cycle(); #1;
    chk("fit_done", {done, err}, 2'b10);

    // ---- reset in the middle of a burst
    $display("txn read incr addr=0x000 len=4 reset mid-burst");
    next_cycle();
    send_cmd(1'b0, 10'h000, 2'd3, 8'd4);
    next_cycle(); rst = 1'b1; #1;
    chk("rst_mid_seq", {bus.htrans, bus.haddr}, {2'b11, 10'h008});
    next_cycle(); rst = 1'b0; #1;
    chk("rst_mid_idle", {bus.htrans, cmd_ready, done, rdata_valid}, 5'b00100);
    next_cycle(); #1;
    chk("rst_mid_no_done", {done, bus.htrans}, 3'b000);

    // ---- stalled data phase: timeout or indefinite wait
    $display("txn read single addr=0x080 hready held low");
    send_cmd(1'b0, 10'h080, 2'd3, 8'd1); #1;
    chk("to_c1", bus.htrans, 2'b10);
    next_cycle(); bus.hready = 1'b0; bus.hrdata = 64'h7777;
`ifdef AHB_MGR_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_no_done", done, 1'b0);
      next_cycle();
    end
    #1;
    chk("to_done_err", {done, err, cmd_ready, bus.htrans}, 5'b11100);
    bus.hready = 1'b1;
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("nto_wait_no_done", {done, bus.htrans}, 3'b000);
      next_cycle();
    end
    bus.hready = 1'b1; #1;
    next_cycle(); #1;
    chk("nto_done", {done, err, rdata_valid}, 3'b101);
    chk("nto_rdata", rdata, 64'h7777);
`endif
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
